fir_filter: RTL and testbench

FIR_FILTER -- requirements
Module: fir_filter

---
 rtl/fir_pkg.sv | 32 +++
 rtl/fir_tap.sv | 36 +++
 rtl/fir_filter.sv | 81 ++++++++
 tb/tb_fir_filter.sv | 169 ++++++++++++++++
 4 files changed

// File: rtl/fir_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | fir_pkg                                                              |
// | Default FIR widths, tap count and the symmetric coefficient set.     |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
package fir_pkg;

  localparam int DEFAULT_TAPS   = 8;
  localparam int DEFAULT_DATA_W = 16;
  localparam int DEFAULT_COEF_W = 16;
  localparam int DEFAULT_OUT_W  = 32;

  // h[0] multiplies the newest sample.
  localparam logic signed [DEFAULT_COEF_W-1:0] FIR_COEFS [0:DEFAULT_TAPS-1] = '{
    16'sd1, 16'sd2, 16'sd3, 16'sd4, 16'sd4, 16'sd3, 16'sd2, 16'sd1
  };

  // Taps beyond the stored set read as zero, so larger TAPS values still elaborate.
  function automatic int coef_at(input int idx);
    int c;
    c = 0;
    for (int k = 0; k < DEFAULT_TAPS; k++) begin
      if (k == idx) begin
        c = int'(FIR_COEFS[k]);
      end
    end
    return c;
  endfunction

endpackage
`default_nettype wire

// File: rtl/fir_tap.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | fir_tap                                                              |
// | One FIR tap: delay-line register plus full-precision coefficient     |
// | multiply of the sample presented to it.                              |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module fir_tap
  import fir_pkg::*;
#(
  parameter int                        DATA_W = DEFAULT_DATA_W,
  parameter int                        COEF_W = DEFAULT_COEF_W,
  parameter logic signed [COEF_W-1:0]  COEF   = '0
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic signed [DATA_W-1:0]          sample_in,
  output logic signed [DATA_W-1:0]          sample_q,
  output logic signed [DATA_W+COEF_W-1:0]   product
);

  localparam int PROD_W = DATA_W + COEF_W;

  always_ff @(posedge clk) begin
    if (reset) begin
      sample_q <= '0;
    end else begin
      sample_q <= sample_in;
    end
  end

  // Both operands widened first so the product is exact and signed.
  assign product = PROD_W'(sample_in) * PROD_W'(COEF);

endmodule
`default_nettype wire

// File: rtl/fir_filter.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | fir_filter                                                           |
// | Direct-form FIR filter, one sample per clock, registered output.     |
// | Option: FIR_PIPELINE_EN registers the products (latency 2 vs 1).     |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module fir_filter
  import fir_pkg::*;
#(
  parameter int TAPS   = DEFAULT_TAPS,
  parameter int DATA_W = DEFAULT_DATA_W,
  parameter int COEF_W = DEFAULT_COEF_W,
  parameter int OUT_W  = DEFAULT_OUT_W
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic signed [DATA_W-1:0] xn,
  output logic signed [OUT_W-1:0]  yn
);

  localparam int PROD_W = DATA_W + COEF_W;

  // samples[0] is the live input; samples[i+1] is the delay-line stage d[i].
  logic signed [DATA_W-1:0] samples  [0:TAPS];
  logic signed [PROD_W-1:0] products [0:TAPS-1];
  logic signed [PROD_W-1:0] prod_src [0:TAPS-1];
  logic signed [OUT_W-1:0]  acc;

  assign samples[0] = xn;

  for (genvar i = 0; i < TAPS; i++) begin : g_tap
    fir_tap #(
      .DATA_W (DATA_W),
      .COEF_W (COEF_W),
      .COEF   (COEF_W'(coef_at(i)))
    ) u_tap (
      .clk       (clk),
      .reset     (reset),
      .sample_in (samples[i]),
      .sample_q  (samples[i+1]),
      .product   (products[i])
    );
  end

`ifdef FIR_PIPELINE_EN
  logic signed [PROD_W-1:0] prod_q [0:TAPS-1];

  always_ff @(posedge clk) begin
    for (int i = 0; i < TAPS; i++) begin
      if (reset) begin
        prod_q[i] <= '0;
      end else begin
        prod_q[i] <= products[i];
      end
    end
  end

  assign prod_src = prod_q;
`else
  assign prod_src = products;
`endif

  // Sign-extend each product to OUT_W; the sum wraps modulo 2^OUT_W.
  always_comb begin
    acc = '0;
    for (int i = 0; i < TAPS; i++) begin
      acc = acc + OUT_W'(prod_src[i]);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      yn <= '0;
    end else begin
      yn <= acc;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_fir_filter.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_fir_filter                                                        |
// | Scoreboard bench: directed and random samples against a history-     |
// | based convolution model. Honours FIR_PIPELINE_EN for output latency. |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module tb_fir_filter;

  localparam int TAPS  = 8;
  localparam int OUT_W = 32;
`ifdef FIR_PIPELINE_EN
  localparam int DELAY = 1;
`else
  localparam int DELAY = 0;
`endif
  localparam longint H [0:TAPS-1] = '{1, 2, 3, 4, 4, 3, 2, 1};

  typedef struct {
    int     due;
    longint val;
    int     tag;
  } exp_t;

  logic               clk = 1'b0;
  logic               reset = 1'b1;
  logic signed [15:0] xn = 16'sd500;
  logic signed [31:0] yn;

  int     edge_no = 0;
  int     checks  = 0;
  int     errors  = 0;
  int     cur_tag = 0;
  exp_t   exp_q[$];
  longint hist[$];
  bit     rst_at[int];

  fir_filter dut (
    .clk   (clk),
    .reset (reset),
    .xn    (xn),
    .yn    (yn)
  );

  always #5 clk = ~clk;
  always @(posedge clk) edge_no <= edge_no + 1;

  function automatic string tag_name(input int t);
    case (t)
      0: return "reset";
      1: return "impulse";
      2: return "ramp";
      3: return "step";
      4: return "midreset";
      5: return "extreme_neg";
      6: return "extreme_pos";
      7: return "random";
      default: return "drain";
    endcase
  endfunction

  // One sample per edge; the expected output of that edge is queued for the monitor.
  task automatic drive(input int x, input bit r, input bit use_lit, input longint lit);
    longint m;
    @(negedge clk);
    xn    = 16'(x);
    reset = r;
    @(posedge clk);
    #1;
    m = 0;
    if (r) begin
      hist.delete();
      rst_at[edge_no] = 1'b1;
    end else begin
      hist.push_front(longint'(x));
      if (hist.size() > TAPS) void'(hist.pop_back());
      foreach (hist[i]) m += H[i] * hist[i];
      if (use_lit) m = lit;
    end
    exp_q.push_back('{due: edge_no + DELAY, val: m, tag: cur_tag});
  endtask

  exp_t   mon_e;
  longint mon_v;
  always @(negedge clk) begin
    while (exp_q.size() > 0 && exp_q[0].due < edge_no) begin
      mon_e = exp_q.pop_front();
      checks++;
      errors++;
      $display("FAIL %s stale entry due=%0d at edge=%0d", tag_name(mon_e.tag), mon_e.due, edge_no);
    end
    if (exp_q.size() > 0 && exp_q[0].due == edge_no) begin
      mon_e = exp_q.pop_front();
      mon_v = rst_at.exists(edge_no) ? 0 : mon_e.val;
      checks++;
      if (yn !== 32'(mon_v)) begin
        errors++;
        $display("FAIL %s edge=%0d yn=%0d expected=%0d", tag_name(mon_e.tag), edge_no, yn, 32'(mon_v));
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog timeout at edge=%0d", edge_no);
    $fatal(1, "timeout");
  end

  localparam longint RAMP_Y [0:11] = '{100, 400, 1000, 2000, 2900, 3500, 3600, 3000, 2000, 1100, 400, 0};
  localparam longint STEP_Y [0:8]  = '{100, 300, 600, 1000, 1400, 1700, 1900, 2000, 2000};

  initial begin
    logic signed [15:0] rx;
    // Reset held two cycles with a non-zero input that must be ignored.
    cur_tag = 0;
    drive(500, 1'b1, 1'b0, 0);
    drive(500, 1'b1, 1'b0, 0);
    for (int i = 1; i < TAPS; i++) begin
      checks++;
      if (dut.samples[i] !== 16'sd0) begin
        errors++;
        $display("FAIL reset_delay_line d[%0d]=%0d expected=0", i - 1, dut.samples[i]);
      end
    end

    cur_tag = 1;
    drive(100, 1'b0, 1'b1, 100);
    for (int i = 1; i < TAPS; i++) drive(0, 1'b0, 1'b1, H[i] * 100);
    drive(0, 1'b0, 1'b1, 0);
    drive(0, 1'b0, 1'b1, 0);

    cur_tag = 2;
    for (int i = 0; i < 12; i++) drive((i < 4) ? (i + 1) * 100 : 0, 1'b0, 1'b1, RAMP_Y[i]);

    cur_tag = 3;
    for (int i = 0; i < 12; i++) drive(100, 1'b0, 1'b1, (i < 8) ? ((i < 7) ? STEP_Y[i] : 2000) : 2000);

    cur_tag = 4;
    drive(777, 1'b1, 1'b0, 0);
    for (int i = 0; i < 11; i++) drive(100, 1'b0, 1'b1, (i < 9) ? STEP_Y[i] : 2000);

    cur_tag = 5;
    drive(0, 1'b1, 1'b0, 0);
    for (int i = 0; i < 10; i++) drive(-32768, 1'b0, i >= 7, -655360);
    cur_tag = 6;
    for (int i = 0; i < 10; i++) drive(32767, 1'b0, i >= 7, 655340);

    cur_tag = 7;
    for (int i = 0; i < 300; i++) begin
      rx = 16'($urandom);
      drive(int'(rx), $urandom_range(0, 24) == 0, 1'b0, 0);
    end

    cur_tag = 8;
    for (int i = 0; i < TAPS + 1; i++) drive(0, 1'b0, 1'b0, 0);
    repeat (DELAY + 2) @(negedge clk);
    #1;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain pending=%0d expected=0", exp_q.size());
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
